// File: rtl/ddr_line_reader.sv
// ddr_line_reader: AXI read master that fetches a video frame line by line in
// fixed-length INCR bursts, buffers beats in a FIFO and streams them out with
// start-of-frame / start-of-line tags.
// Optional feature macro: DDR_LINE_READER_CHECK_EN (axi_rid check, underrun counter).
module ddr_line_reader #(
    parameter int unsigned LINE_BEATS  = 320,
    parameter int unsigned LINES       = 720,
    parameter logic [31:0] LINE_STRIDE = 32'h1400,
    parameter int unsigned BURST_LEN   = 16,
    parameter int unsigned FIFO_DEPTH  = 64,
    parameter logic [7:0]  AXI_ID      = 8'h00
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start_i,
    input  logic [31:0]  base_addr_i,
    output logic         busy_o,
    output logic         frame_done_o,
    output logic         err_o,
    output logic [7:0]   axi_aid,
    output logic [31:0]  axi_aaddr,
    output logic [7:0]   axi_alen,
    output logic [2:0]   axi_asize,
    output logic [1:0]   axi_aburst,
    output logic [1:0]   axi_alock,
    output logic         axi_atype,
    output logic         axi_avalid,
    input  logic         axi_aready,
    input  logic [7:0]   axi_rid,
    input  logic [127:0] axi_rdata,
    input  logic [1:0]   axi_rresp,
    input  logic         axi_rlast,
    input  logic         axi_rvalid,
    output logic         axi_rready,
`ifdef DDR_LINE_READER_CHECK_EN
    output logic [15:0]  underrun_cnt_o,
`endif
    output logic [127:0] pix_data_o,
    output logic         pix_valid_o,
    input  logic         pix_ready_i,
    output logic         pix_sof_o,
    output logic         pix_sol_o
);

    localparam int unsigned AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BW   = $clog2(LINE_BEATS + 1);
    localparam int unsigned LW   = $clog2(LINES + 1);
    localparam int unsigned LENW = 9;

    typedef struct packed {
        logic         sof;
        logic         sol;
        logic [127:0] data;
    } beat_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_DATA  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       line_addr_q, line_addr_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [LW-1:0]     line_q, line_d;
    logic [LENW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [CW-1:0]     reserved_q, reserved_d;
    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              err_q, err_d;
    logic              avalid_q, avalid_d;
    logic [31:0]       aaddr_q, aaddr_d;
    logic [7:0]        alen_q, alen_d;
    logic              rready_q, rready_d;

    beat_t             mem [FIFO_DEPTH];
    beat_t             wr_beat;
    beat_t             head;

    logic [LENW-1:0]   cur_len;
    logic              start_acc;
    logic              a_hs;
    logic              push;
    logic              pop;
    logic              is_last;
    logic              burst_end;
    logic              line_end;
    logic              frame_end;
    logic              space_ok;
    logic              last_pop;
    logic              beat_bad;

    // Length of the burst at the current position: full burst or line tail
    always_comb begin
        cur_len = LENW'(BURST_LEN);
        if ((LINE_BEATS - 32'(beat_q)) < BURST_LEN) begin
            cur_len = LENW'(LINE_BEATS - 32'(beat_q));
        end
    end

    // Handshake and bookkeeping events shared by the FSM and datapath
    always_comb begin
        start_acc = (state_q == S_IDLE) && start_i;
        a_hs      = avalid_q && axi_aready;
        push      = rready_q && axi_rvalid;
        pop       = (count_q != '0) && pix_ready_i;
        is_last   = (rx_cnt_q == (cur_len - LENW'(1)));
        burst_end = push && is_last;
        line_end  = ((32'(beat_q) + 32'(cur_len)) == LINE_BEATS);
        frame_end = line_end && ((32'(line_q) + 32'd1) == LINES);
        space_ok  = ((FIFO_DEPTH - 32'(count_q) - 32'(reserved_q)) >= 32'(cur_len));
        last_pop  = (state_q == S_DRAIN) && pop && (count_q == CW'(1));
        beat_bad  = (axi_rresp != 2'b00) || (axi_rlast != is_last);
`ifdef DDR_LINE_READER_CHECK_EN
        if (axi_rid != AXI_ID) begin
            beat_bad = 1'b1;
        end
`endif
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i)   state_d = S_ADDR;
            S_ADDR:  if (a_hs)      state_d = S_DATA;
            S_DATA:  if (burst_end) state_d = (frame_end ? S_DRAIN : S_ADDR);
            S_DRAIN: if (last_pop)  state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // FSM outputs: address channel, read ready, sticky error, frame done
    always_comb begin
        avalid_d     = 1'b0;
        aaddr_d      = aaddr_q;
        alen_d       = alen_q;
        rready_d     = (state_d == S_DATA);
        err_d        = err_q;
        frame_done_o = last_pop;
        if (state_q == S_ADDR) begin
            // Fields are captured once per request and then held until accepted
            if (!avalid_q) begin
                aaddr_d = line_addr_q + (32'(beat_q) << 4);
                alen_d  = 8'(cur_len - LENW'(1));
            end
            avalid_d = !a_hs && (avalid_q || space_ok);
        end
        if (start_acc) begin
            err_d = 1'b0;
        end
        if (push && beat_bad) begin
            err_d = 1'b1;
        end
    end

    // Frame position, burst beat count, reservation and FIFO pointers
    always_comb begin
        line_addr_d = line_addr_q;
        beat_d      = beat_q;
        line_d      = line_q;
        rx_cnt_d    = rx_cnt_q;
        reserved_d  = reserved_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        wr_ptr_d    = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d    = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        if (start_acc) begin
            line_addr_d = base_addr_i;
            beat_d      = '0;
            line_d      = '0;
            rx_cnt_d    = '0;
            reserved_d  = '0;
        end
        if (a_hs) begin
            reserved_d = CW'(cur_len);
            rx_cnt_d   = '0;
        end
        if (push) begin
            reserved_d = reserved_q - CW'(1);
            rx_cnt_d   = rx_cnt_q + LENW'(1);
        end
        // Burst closes on the expected count regardless of rlast
        if (burst_end) begin
            rx_cnt_d   = '0;
            reserved_d = '0;
            if (line_end) begin
                beat_d      = '0;
                line_d      = LW'(32'(line_q) + 32'd1);
                line_addr_d = line_addr_q + LINE_STRIDE;
            end else begin
                beat_d = BW'(32'(beat_q) + 32'(cur_len));
            end
        end
    end

    // Control and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_addr_q <= '0;
            beat_q      <= '0;
            line_q      <= '0;
            rx_cnt_q    <= '0;
            reserved_q  <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            err_q       <= 1'b0;
            avalid_q    <= 1'b0;
            aaddr_q     <= '0;
            alen_q      <= '0;
            rready_q    <= 1'b0;
        end else begin
            line_addr_q <= line_addr_d;
            beat_q      <= beat_d;
            line_q      <= line_d;
            rx_cnt_q    <= rx_cnt_d;
            reserved_q  <= reserved_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            err_q       <= err_d;
            avalid_q    <= avalid_d;
            aaddr_q     <= aaddr_d;
            alen_q      <= alen_d;
            rready_q    <= rready_d;
        end
    end

    // Beat tags: first beat of the frame and first beat of each line
    always_comb begin
        wr_beat.data = axi_rdata;
        wr_beat.sol  = (beat_q == '0) && (rx_cnt_q == '0);
        wr_beat.sof  = wr_beat.sol && (line_q == '0);
    end

    // FIFO storage; contents need no reset since occupancy gates the outputs
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_beat;
        end
    end

    // Stream head, forced to zero while the FIFO is empty
    always_comb begin
        head        = mem[rd_ptr_q];
        pix_valid_o = (count_q != '0);
        pix_data_o  = pix_valid_o ? head.data : '0;
        pix_sof_o   = pix_valid_o && head.sof;
        pix_sol_o   = pix_valid_o && head.sol;
    end

`ifdef DDR_LINE_READER_CHECK_EN
    logic [15:0] underrun_q, underrun_d;

    // Saturating count of cycles where the consumer waits on an empty FIFO
    always_comb begin
        underrun_d = underrun_q;
        if (start_acc) begin
            underrun_d = '0;
        end else if (busy_o && pix_ready_i && (count_q == '0) && (underrun_q != 16'hFFFF)) begin
            underrun_d = underrun_q + 16'd1;
        end
    end

    // Underrun counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun_q <= '0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign underrun_cnt_o = underrun_q;
`else
    logic unused_rid;
    assign unused_rid = ^axi_rid;
`endif

    assign busy_o     = (state_q != S_IDLE);
    assign err_o      = err_q;
    assign axi_aid    = AXI_ID;
    assign axi_aaddr  = aaddr_q;
    assign axi_alen   = alen_q;
    assign axi_asize  = 3'd4;
    assign axi_aburst = 2'b01;
    assign axi_alock  = 2'b00;
    assign axi_atype  = 1'b0;
    assign axi_avalid = avalid_q;
    assign axi_rready = rready_q;

endmodule

// File: doc/ddr_line_reader.md
Name: ddr_line_reader

Overview:
- Upstream AXI read master for the DDR controller. It fetches one video frame from DDR, line by line, in fixed-length INCR bursts.
- Uses the controller's combined address channel with axi_atype=0 (read).
- Buffers returned 128-bit beats in an internal FIFO.
- Presents the beats as a valid/ready stream with start-of-frame and start-of-line markers to the HDMI pixel unpacker downstream.

Parameters:
- LINE_BEATS, 320, 128-bit beats per line (1280 px x 32 bpp / 16 B)
- LINES, 720, lines per frame
- LINE_STRIDE, 32'h1400, byte distance between line starts
- BURST_LEN, 16, beats per full burst (1..256)
- FIFO_DEPTH, 64, beat FIFO depth; power of 2, >= BURST_LEN
- AXI_ID, 8'h00, constant axi_aid value

Ports:
- clk  in  1  single clock, shared with DdrCtrl AXI side
- reset_n  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse: begin frame fetch
- base_addr_i  in  32  frame base byte address, sampled on accepted start_i; 16-byte aligned
- busy_o  out  1  frame fetch in progress
- frame_done_o  out  1  one-cycle pulse when last beat of frame leaves the FIFO
- err_o  out  1  sticky error: bad rresp or rlast misalignment; cleared by reset or accepted start_i
- axi_aid  out  8  = AXI_ID
- axi_aaddr  out  32  burst start byte address
- axi_alen  out  8  beats-1
- axi_asize  out  3  constant 3'd4 (16 B)
- axi_aburst  out  2  constant 2'b01 (INCR)
- axi_alock  out  2  constant 0
- axi_atype  out  1  constant 0 (read)
- axi_avalid  out  1  address valid
- axi_aready  in  1  address accepted
- axi_rid  in  8  ignored except under the optional feature
- axi_rdata  in  128  read data
- axi_rresp  in  2  read response
- axi_rlast  in  1  last beat of burst
- axi_rvalid  in  1  read data valid
- axi_rready  out  1  read data ready
- pix_data_o  out  128  FIFO head beat
- pix_valid_o  out  1  head valid
- pix_ready_i  in  1  consumer ready
- pix_sof_o  out  1  head is first beat of frame
- pix_sol_o  out  1  head is first beat of a line

Behaviour:
- Reset: every output 0 except the constants (axi_aid=AXI_ID, axi_asize=4, axi_aburst=1); FIFO empty, counters 0, FSM IDLE.
- FSM IDLE: start_i -> latch base, clear err_o, line=0, beat=0 -> ADDR. start_i while busy_o=1 is ignored.
- ADDR:
  - Wait until FIFO free space (depth - occupancy - reserved) >= current burst length, then assert axi_avalid.
  - axi_aaddr = base + line*LINE_STRIDE + beat*16.
  - Burst length = min(BURST_LEN, LINE_BEATS-beat); a short tail burst is issued when LINE_BEATS is not a multiple of BURST_LEN.
  - axi_avalid and all address fields stay stable until axi_aready; handshake on the same cycle -> DATA.
- DATA:
  - Exactly one burst outstanding.
  - axi_rready = 1 (space is guaranteed by reservation).
  - Each rvalid beat is written to the FIFO with its sol/sof tags.
  - rresp != 0 -> err_o=1; the data is still stored.
  - rlast on a beat other than the expected last, or missing on the expected last -> err_o=1; the burst ends at the expected count regardless.
  - At burst end: beat += len; if beat==LINE_BEATS then beat=0, line++. If line==LINES -> DRAIN, else -> ADDR.
- DRAIN: wait for FIFO empty. On the cycle the last beat pops, frame_done_o=1, busy_o drops next cycle -> IDLE.
- busy_o = 1 in ADDR/DATA/DRAIN.
- Stream: pix_valid_o = FIFO non-empty. Pop on pix_valid_o & pix_ready_i. Data and tags come straight from the FIFO head; no added latency beyond a one-cycle write-to-read FIFO latency.
- FIFO full and write on the same cycle cannot occur (reservation). Simultaneous push and pop keeps occupancy unchanged.
- Address arithmetic is 32-bit and wraps silently.
- Reset mid-operation: the FIFO is flushed and any outstanding AXI burst is abandoned. The controller must be reset together with this block.

Optional Feature:
- Macro DDR_LINE_READER_CHECK_EN.
- With it defined:
  - Each R beat with axi_rid != AXI_ID also sets err_o.
  - A 16-bit saturating underrun counter, output port underrun_cnt_o [15:0], counts cycles with busy_o=1, pix_ready_i=1 and FIFO empty. It is cleared on accepted start_i and reset.
- Without it: axi_rid is ignored, and underrun_cnt_o and its logic are absent.

Test Plan:
1. LINE_BEATS=20, BURST_LEN=8, LINES=2, LINE_STRIDE=32'h200, base 32'h1000, aready/rvalid always 1, pix_ready_i=1 -> addresses 1000/1080/1100 (alen 7,7,3), then 1200/1280/1300; 40 beats out; sof on beat 0; sol on beats 0 and 20; one frame_done_o pulse; err_o=0.
2. Same config, pix_ready_i=0 with FIFO_DEPTH=16 -> exactly 2 bursts issued (16 beats); axi_avalid held low thereafter. pix_ready_i=1 -> fetch resumes, no beat lost or duplicated.
3. aready delayed 5 cycles -> axi_aaddr/axi_alen stable throughout the wait; single handshake.
4. rresp=2'b10 on beat 3 of burst 1 -> err_o=1 from the next cycle, all 40 beats still delivered; next start_i clears err_o.
5. rlast asserted on beat 5 of an 8-beat burst -> err_o=1; FSM still consumes 8 beats and issues the next address.
6. reset_n low during DATA of line 1 -> all outputs at reset values immediately; new start_i after release restarts at the base address with sof set.
